// File: rtl/fp_wb_stage.sv
// Purpose: writeback stage after fp_rnd; applies FMA flag fix-ups, buffers the result
// and keeps the sticky fflags. Latency: 1 cycle. Backpressure: 2-entry skid buffer,
// ready_o registered (no comb path from ready_i). Optional macro FP_WB_CANON_NAN_EN.

package fp_pkg;

  typedef enum logic [1:0] {FP32, FP64, FP16, BF16} fp_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      BF16:    return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      BF16:    return 8;
      default: return 8;
    endcase
  endfunction

endpackage

module fp_wb_stage
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned W  = fp_width(FP_FORMAT)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] result_i,
  input  logic [4:0]   flags_i,
  input  logic         u_exp_zero_i,
  input  logic [1:0]   rs_i,
  input  logic         mul_ovf_i,
  input  logic         mul_uf_i,
  input  logic         mul_uround_out_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] result_o,
  output logic [4:0]   flags_o,
  input  logic         fflags_we_i,
  input  logic [4:0]   fflags_wdata_i,
  output logic [4:0]   fflags_o
);

  localparam int unsigned EB = fp_exp_bits(FP_FORMAT);
  localparam int unsigned MB = W - 1 - EB;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e       state_q, state_d;
  logic         ready_q;
  logic         accept, xfer;
  logic         ld_main, ld_skid, skid_to_main;

  logic [W-1:0] main_res_q, skid_res_q, res_in;
  status_t      main_flg_q, skid_flg_q;
  status_t      flg_in, flg_fix;
  logic [4:0]   fflags_q;

  logic [EB-1:0] exp_f;
  logic          uf_fix, uf_fix1;

  assign exp_f  = result_i[W-2 -: EB];
  assign flg_in = status_t'(flags_i);

  // When the product underflowed, fp_rnd's UF/NX were computed on a value that
  // already lost its range information, so they are rebuilt from the raw bits.
  always_comb begin
    uf_fix     = (exp_f == '0) & (|rs_i);
    uf_fix1    = u_exp_zero_i & (exp_f == EB'(1)) & mul_uround_out_i;
    flg_fix    = flg_in;
    flg_fix.of = flg_in.of | mul_ovf_i;
    flg_fix.uf = mul_uf_i ? (uf_fix | uf_fix1) : flg_in.uf;
    flg_fix.nx = mul_uf_i ? (|rs_i) : (flg_in.nx | mul_ovf_i);
  end

`ifdef FP_WB_CANON_NAN_EN
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
  logic is_nan;
  assign is_nan = (&exp_f) & (|result_i[MB-1:0]);
  assign res_in = is_nan ? CANON_NAN : result_i;
`else
  assign res_in = result_i;
`endif

  assign accept = valid_i & ready_q;
  assign xfer   = (state_q != EMPTY) & ready_i;

  always_comb begin
    state_d      = state_q;
    ld_main      = 1'b0;
    ld_skid      = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ld_main = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({xfer, accept})
          2'b11: ld_main = 1'b1;
          2'b10: state_d = EMPTY;
          2'b01: begin
            ld_skid = 1'b1;
            state_d = TWO;
          end
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        if (xfer) begin
          skid_to_main = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      main_res_q <= '0;
      main_flg_q <= '0;
      skid_res_q <= '0;
      skid_flg_q <= '0;
    end else begin
      if (ld_main) begin
        main_res_q <= res_in;
        main_flg_q <= flg_fix;
      end else if (skid_to_main) begin
        main_res_q <= skid_res_q;
        main_flg_q <= skid_flg_q;
      end
      if (ld_skid) begin
        skid_res_q <= res_in;
        skid_flg_q <= flg_fix;
      end
    end
  end

  // A CSR write colliding with a transfer must still keep that op's flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fflags_q <= '0;
    end else if (fflags_we_i && xfer) begin
      fflags_q <= fflags_wdata_i | main_flg_q;
    end else if (fflags_we_i) begin
      fflags_q <= fflags_wdata_i;
    end else if (xfer) begin
      fflags_q <= fflags_q | main_flg_q;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = (state_q != EMPTY);
  assign result_o = main_res_q;
  assign flags_o  = main_flg_q;
  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fp_wb_stage.sv
// Directed bench for fp_wb_stage: drives and samples on the falling clock edge.
module tb_fp_wb_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i, ready_o;
  logic [31:0] result_i;
  logic [4:0]  flags_i;
  logic        u_exp_zero_i;
  logic [1:0]  rs_i;
  logic        mul_ovf_i, mul_uf_i, mul_uround_out_i;
  logic        valid_o, ready_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;
  logic        fflags_we_i;
  logic [4:0]  fflags_wdata_i;
  logic [4:0]  fflags_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fp_wb_stage dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .result_i         (result_i),
    .flags_i          (flags_i),
    .u_exp_zero_i     (u_exp_zero_i),
    .rs_i             (rs_i),
    .mul_ovf_i        (mul_ovf_i),
    .mul_uf_i         (mul_uf_i),
    .mul_uround_out_i (mul_uround_out_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .result_o         (result_o),
    .flags_o          (flags_o),
    .fflags_we_i      (fflags_we_i),
    .fflags_wdata_i   (fflags_wdata_i),
    .fflags_o         (fflags_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic [31:0] res, input logic [4:0] flg, input logic [1:0] rs,
                          input logic ovf, input logic uf, input logic uro, input logic uez);
    valid_i          = 1'b1;
    result_i         = res;
    flags_i          = flg;
    rs_i             = rs;
    mul_ovf_i        = ovf;
    mul_uf_i         = uf;
    mul_uround_out_i = uro;
    u_exp_zero_i     = uez;
  endtask

  task automatic idle();
    drive_op(32'h0, 5'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    valid_i = 1'b0;
  endtask

  // Single op with ready_i=1: check the fixed-up flags, then let it drain.
  task automatic flag_case(input string tag, input logic [31:0] res, input logic [4:0] flg,
                           input logic [1:0] rs, input logic ovf, input logic uf,
                           input logic uro, input logic uez, input logic [4:0] exp_flg);
    drive_op(res, flg, rs, ovf, uf, uro, uez);
    @(negedge clk_i);
    idle();
    chk(tag, {27'b0, flags_o}, {27'b0, exp_flg});
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] nan_exp;
    idle();
    reset_i        = 1'b1;
    ready_i        = 1'b0;
    fflags_we_i    = 1'b0;
    fflags_wdata_i = 5'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid_o",  {31'b0, valid_o}, 32'd0);
    chk("rst_ready_o",  {31'b0, ready_o}, 32'd1);
    chk("rst_result_o", result_o, 32'h0);
    chk("rst_flags_o",  {27'b0, flags_o}, 32'h0);
    chk("rst_fflags_o", {27'b0, fflags_o}, 32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // single op, 1-cycle latency
    ready_i = 1'b1;
    drive_op(32'h3F800000, 5'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    chk("single_valid",  {31'b0, valid_o}, 32'd1);
    chk("single_result", result_o, 32'h3F800000);
    chk("single_flags",  {27'b0, flags_o}, 32'h0);
    chk("single_fflags", {27'b0, fflags_o}, 32'h0);
    @(negedge clk_i);
    chk("single_drained", {31'b0, valid_o}, 32'd0);
    chk("single_fflags2", {27'b0, fflags_o}, 32'h0);

    // backpressure: A, B fill the buffer, C is held off
    ready_i = 1'b0;
    drive_op(32'h1, 5'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("bp_ready_after_a", {31'b0, ready_o}, 32'd1);
    drive_op(32'h2, 5'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("bp_ready_after_b", {31'b0, ready_o}, 32'd0);
    chk("bp_main_a",        result_o, 32'h1);
    drive_op(32'h3, 5'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("bp_hold_ready", {31'b0, ready_o}, 32'd0);
    chk("bp_hold_a",     result_o, 32'h1);
    chk("bp_hold_valid", {31'b0, valid_o}, 32'd1);
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_out_b",       result_o, 32'h2);
    chk("bp_ready_again", {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    idle();
    chk("bp_out_c",   result_o, 32'h3);
    chk("bp_valid_c", {31'b0, valid_o}, 32'd1);
    @(negedge clk_i);
    chk("bp_empty", {31'b0, valid_o}, 32'd0);

    // flag fix-ups
    flag_case("uf_rs01",  32'h00000001, 5'b00000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00011);
    flag_case("uf_rs00",  32'h00000001, 5'b00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000);
    flag_case("uf_fix1",  32'h00800000, 5'b00001, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00010);
    flag_case("pass_nv",  32'h40000000, 5'b11010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11010);

    // clear fflags via CSR, then overflow op
    fflags_we_i    = 1'b1;
    fflags_wdata_i = 5'b0;
    @(negedge clk_i);
    fflags_we_i = 1'b0;
    chk("csr_clear", {27'b0, fflags_o}, 32'h0);
    drive_op(32'h7F7FFFFF, 5'b0, 2'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    chk("ovf_flags",       {27'b0, flags_o}, 32'h05);
    chk("ovf_fflags_pre",  {27'b0, fflags_o}, 32'h0);
    @(negedge clk_i);
    chk("ovf_fflags_post", {27'b0, fflags_o}, 32'h05);

    // CSR write colliding with a transfer
    fflags_we_i    = 1'b1;
    fflags_wdata_i = 5'b10000;
    @(negedge clk_i);
    fflags_we_i = 1'b0;
    chk("csr_write", {27'b0, fflags_o}, 32'h10);
    ready_i = 1'b0;
    drive_op(32'h40000000, 5'b00001, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    chk("coll_flags_o", {27'b0, flags_o}, 32'h01);
    ready_i        = 1'b1;
    fflags_we_i    = 1'b1;
    fflags_wdata_i = 5'b0;
    @(negedge clk_i);
    fflags_we_i = 1'b0;
    chk("coll_fflags", {27'b0, fflags_o}, 32'h01);

    // NaN handling
`ifdef FP_WB_CANON_NAN_EN
    nan_exp = 32'h7FC00000;
`else
    nan_exp = 32'h7FA00001;
`endif
    drive_op(32'h7FA00001, 5'b10000, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    chk("nan_result", result_o, nan_exp);
    chk("nan_flags",  {27'b0, flags_o}, 32'h10);
    @(negedge clk_i);

    // mid-flight reset with the buffer full
    ready_i = 1'b0;
    drive_op(32'h11, 5'b00001, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    drive_op(32'h22, 5'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    chk("mid_full_ready", {31'b0, ready_o}, 32'd0);
    chk("mid_fflags_pre", {27'b0, fflags_o}, 32'h11);
    #2 reset_i = 1'b1;
    #1;
    chk("mid_rst_valid",  {31'b0, valid_o}, 32'd0);
    chk("mid_rst_ready",  {31'b0, ready_o}, 32'd1);
    chk("mid_rst_fflags", {27'b0, fflags_o}, 32'h0);
    chk("mid_rst_result", result_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("mid_post_valid",  {31'b0, valid_o}, 32'd0);
    chk("mid_post_fflags", {27'b0, fflags_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_wb_stage.md
Name: fp_wb_stage

Overview:
- Registered writeback stage directly downstream of fp_rnd (and fp_fma's side outputs).
- Applies the FMA overflow/underflow flag fix-ups to the rounded result.
- Buffers result and flags through a 2-entry valid/ready skid buffer, 1-cycle latency.
- Keeps the sticky architectural fflags accumulator that the CSR file reads and writes.

Parameters:
- FP_FORMAT, FP32: float format from fp_pkg; sets W (32 for FP32) and the exponent field position (bits [30:23] for FP32).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- valid_i  in  1  upstream result valid
- ready_o  out  1  stage can accept
- result_i  in  W  rounded result (rnd_result.result)
- flags_i  in  5  status_t from fp_rnd {NV,DZ,OF,UF,NX}
- u_exp_zero_i  in  1  unrounded exponent == 0
- rs_i  in  2  round/sticky bits of unrounded result
- mul_ovf_i  in  1  FMA product overflow
- mul_uf_i  in  1  FMA product underflow
- mul_uround_out_i  in  1  FMA product rounded out of subnormal range
- valid_o  out  1  output valid
- ready_i  in  1  consumer ready
- result_o  out  W  registered result
- flags_o  out  5  registered fixed-up flags
- fflags_we_i  in  1  CSR write strobe
- fflags_wdata_i  in  5  CSR write data
- fflags_o  out  5  sticky accumulated flags

Behaviour:
- Reset (asynchronous, while reset_i=1):
  - valid_o=0, ready_o=1, result_o=0, flags_o=0, fflags_o=0.
  - Both buffer entries are empty.
  - An in-flight transfer is discarded.
- Flag fix-up, combinational on input (E = exponent field of result_i):
  - uf_fix = (E==0) & |rs_i
  - uf_fix1 = u_exp_zero_i & (E==1) & mul_uround_out_i
  - OF = flags_i.OF | mul_ovf_i
  - UF = mul_uf_i ? (uf_fix | uf_fix1) : flags_i.UF
  - NX = mul_uf_i ? |rs_i : (flags_i.NX | mul_ovf_i)
  - NV and DZ pass through unchanged.
- Handshakes:
  - Input accepted when valid_i & ready_o.
  - Output transfers when valid_o & ready_i.
  - valid_o never drops without a transfer.
  - result_o and flags_o are held stable while valid_o=1 and ready_i=0.
- Buffer states: EMPTY (main empty), ONE (main full, skid empty), TWO (both full).
  - EMPTY: accept -> load main, go to ONE.
  - ONE, transfer and accept: reload main, stay ONE.
  - ONE, transfer only: go to EMPTY.
  - ONE, accept only: load skid, go to TWO.
  - ONE, neither: hold.
  - TWO, transfer: skid -> main, go to ONE.
  - TWO, no transfer: hold.
- ready_o is registered: 1 in EMPTY/ONE, 0 in TWO. There is no combinational path from ready_i to ready_o.
- Latency: data accepted in cycle N appears on result_o in cycle N+1 when the buffer is not backed up.
- Ordering: strictly FIFO, no reordering.
- fflags accumulation happens at the output transfer, not at acceptance:
  - Transfer only: fflags <= fflags | flags_o.
  - fflags_we_i only: fflags <= fflags_wdata_i.
  - fflags_we_i and transfer in the same cycle: fflags <= fflags_wdata_i | flags_o, so the transferring op's flags are never lost.
- Reset mid-operation clears the buffer and fflags immediately; no output transfer is reported.

Optional Feature:
- Macro FP_WB_CANON_NAN_EN.
- Defined: any NaN result_i (E all ones, mantissa nonzero) is replaced at acceptance by the canonical quiet NaN (0x7FC00000 for FP32). Flags are unchanged.
- Undefined: result_i passes through bit-exact.

Test Plan:
- Reset then single op: result_i=0x3F800000, flags_i=0, valid_i pulse, ready_i=1 -> next cycle valid_o=1, result_o=0x3F800000, flags_o=0, fflags_o stays 0.
- Backpressure: 3 back-to-back ops A=0x1, B=0x2, C=0x3 with ready_i=0:
  - Expected: A in main, B in skid, ready_o=0 after B, C held off.
  - Then ready_i=1: outputs A, B, C in order with no loss or duplication.
- FMA underflow fix-up: mul_uf_i=1, result_i=0x00000001 (E=0), rs_i=2'b01, flags_i.UF=0 -> flags_o UF=1, NX=1.
  - Same stimulus with rs_i=0 -> UF=0, NX=0.
- FMA overflow: mul_ovf_i=1, result_i=0x7F7FFFFF, flags_i=0 -> flags_o OF=1, NX=1; after the transfer, fflags_o=5'b00101.
- CSR collision: fflags_o=5'b10000; in the same cycle, fflags_we_i=1 with fflags_wdata_i=0 and a transfer with flags_o=5'b00001 -> fflags_o=5'b00001.
- Mid-flight reset: ready_i=0 and buffer in TWO, assert reset_i between clock edges -> valid_o=0, ready_o=1, fflags_o=0 immediately.
  - With FP_WB_CANON_NAN_EN defined: input 0x7FA00001 -> result_o=0x7FC00000.
